// File: rtl/ring_heater_lock_ctrl.sv
// Thermal lock controller for a resonant ring: heater sweep to find peak drop-port
// power, then three-point dither tracking; re-acquires when the centre power stays low.
module ring_heater_lock_ctrl #(
  parameter int unsigned DAC_W      = 10,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned SWEEP_STEP = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DITHER     = 2,
  parameter int unsigned HYST       = 8,
  parameter int unsigned MIN_PWR    = 64,
  parameter int unsigned LOSS_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             sample_req,
  input  logic             pd_valid,
  input  logic [ADC_W-1:0] pd_sample,
  output logic [DAC_W-1:0] heater_code,
  output logic [DAC_W-1:0] peak_code,
  output logic             busy,
  output logic             locked,
  output logic             err
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);
  localparam logic [DAC_W-1:0] CODE_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, SW_SET, SW_SETTLE, SW_WAIT, GOTO_PK, TR_SET, TR_SETTLE, TR_WAIT, FAIL
  } state_t;

  state_t            state, state_d;
  logic [DAC_W-1:0]  code, c, code_hi, code_lo;
  logic [ADC_W-1:0]  max_pwr, p_hi, p_lo, new_max;
  logic [1:0]        phase;
  logic [LW-1:0]     loss, loss_nxt;
  logic [CW-1:0]     cnt;
  logic [DAC_W:0]    sweep_nxt, hi_sum;
  logic signed [ADC_W:0] diff;
  logic got, sweep_last, settle_done, step_up, step_dn, loss_hit, low_max;

  always_comb begin
    // a pd_valid coinciding with our own request pulse cannot answer it
    got         = pd_valid && !sample_req;
    sweep_nxt   = {1'b0, code} + (DAC_W+1)'(SWEEP_STEP);
    sweep_last  = sweep_nxt > {1'b0, CODE_MAX};
    new_max     = (pd_sample > max_pwr) ? pd_sample : max_pwr;
    low_max     = new_max < ADC_W'(MIN_PWR);
    settle_done = cnt == CW'(SETTLE_CYC - 1);
    hi_sum      = {1'b0, c} + (DAC_W+1)'(DITHER);
    code_hi     = (hi_sum > {1'b0, CODE_MAX}) ? CODE_MAX : hi_sum[DAC_W-1:0];
    code_lo     = (c < DAC_W'(DITHER)) ? '0 : c - DAC_W'(DITHER);
    diff        = $signed({1'b0, p_hi}) - $signed({1'b0, p_lo});
    step_up     = diff > $signed((ADC_W+1)'(HYST));
    step_dn     = diff < -$signed((ADC_W+1)'(HYST));
    loss_nxt    = (pd_sample < ADC_W'(MIN_PWR)) ? loss + 1'b1 : '0;
    loss_hit    = loss_nxt == LW'(LOSS_CNT);
    busy        = (state != IDLE) && (state != FAIL);
    locked      = (state == TR_SET) || (state == TR_SETTLE) || (state == TR_WAIT);
    err         = state == FAIL;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (enable) state_d = SW_SET;
      SW_SET:    state_d = SW_SETTLE;
      SW_SETTLE: if (settle_done) state_d = SW_WAIT;
      SW_WAIT:   if (got) state_d = !sweep_last ? SW_SET : (low_max ? FAIL : GOTO_PK);
      GOTO_PK:   if (settle_done) state_d = TR_SET;
      TR_SET:    state_d = TR_SETTLE;
      TR_SETTLE: if (settle_done) state_d = TR_WAIT;
      TR_WAIT:   if (got) state_d = (phase == 2'd2 && loss_hit) ? SW_SET : TR_SET;
      FAIL:      state_d = FAIL;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; sample_req <= 1'b0; heater_code <= '0; peak_code <= '0;
      code <= '0; c <= '0; max_pwr <= '0; p_hi <= '0; p_lo <= '0;
      phase <= '0; loss <= '0; cnt <= '0;
    end else begin
      state      <= state_d;
      sample_req <= 1'b0;
      case (state)
        IDLE: begin
          heater_code <= '0;
          if (enable) begin code <= '0; max_pwr <= '0; peak_code <= '0; end
        end
        SW_SET, TR_SET: begin
          cnt <= '0;
          if (state == SW_SET) heater_code <= code;
          else heater_code <= (phase == 2'd0) ? code_hi : (phase == 2'd1) ? code_lo : c;
        end
        SW_SETTLE, TR_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (settle_done) sample_req <= 1'b1;
        end
        SW_WAIT: if (got) begin
          max_pwr <= new_max;
          if (pd_sample > max_pwr) peak_code <= code;
          if (!sweep_last) code <= sweep_nxt[DAC_W-1:0];
          else if (low_max) heater_code <= '0;
          else cnt <= '0;
        end
        GOTO_PK: begin
          heater_code <= peak_code;
          cnt <= cnt + 1'b1;
          if (settle_done) begin c <= peak_code; loss <= '0; phase <= '0; end
        end
        TR_WAIT: if (got) begin
          case (phase)
            2'd0: begin p_hi <= pd_sample; phase <= 2'd1; end
            2'd1: begin p_lo <= pd_sample; phase <= 2'd2; end
            default: begin
              phase <= 2'd0;
              loss  <= loss_nxt;
              if (step_up && c != CODE_MAX) c <= c + 1'b1;
              else if (step_dn && c != '0) c <= c - 1'b1;
              // lock lost: restart acquisition exactly as from IDLE
              if (loss_hit) begin
                code <= '0; max_pwr <= '0; peak_code <= '0; loss <= '0;
              end
            end
          endcase
        end
        FAIL:    heater_code <= '0;
        default: heater_code <= '0;
      endcase
      if (!enable) begin heater_code <= '0; sample_req <= 1'b0; end
    end
  end

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Bench for ring_heater_lock_ctrl: Lorentzian ring model answers ADC requests after a
// random delay; an arithmetic reference of sweep/track predicts every heater code.
module tb_ring_heater_lock_ctrl;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, pd_valid = 1'b0;
  logic [11:0] pd_sample = '0;
  logic        sample_req, busy, locked, err;
  logic [9:0]  heater_code, peak_code;

  int total = 0, bad = 0;
  int m_peak = 512, m_amp = 3000;
  bit force_zero = 1'b0;
  int ref_c;
  int last_hi, last_lo, last_c;

  ring_heater_lock_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_req(sample_req),
    .pd_valid(pd_valid), .pd_sample(pd_sample), .heater_code(heater_code),
    .peak_code(peak_code), .busy(busy), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int model(input int code);
    int d;
    if (force_zero) return 0;
    d = code - m_peak;
    return m_amp * 400 / (400 + d * d);
  endfunction

  function automatic int ref_sweep_peak();
    int best = 0, mx = 0;
    for (int k = 0; k <= 1023; k += 4)
      if (model(k) > mx) begin mx = model(k); best = k; end
    return best;
  endfunction

  task automatic serve(output int seen);
    int n = 0;
    seen = -1;
    while (sample_req !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (sample_req !== 1'b1) begin
      total++; bad++;
      $display("FAIL serve_timeout sample_req=%b want=1", sample_req);
      return;
    end
    seen = int'(heater_code);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    pd_sample = 12'(model(seen));
    pd_valid  = 1'b1;
    @(negedge clk);
    pd_valid  = 1'b0;
    pd_sample = 12'($urandom);
  endtask

  task automatic run_sweep(output int nbad);
    int s;
    nbad = 0;
    for (int k = 0; k < 256; k++) begin
      serve(s);
      if (s != k * 4) nbad++;
    end
  endtask

  task automatic do_round(inout int nbad);
    int hi, lo, s, ph, pl;
    hi = (ref_c + 2 > 1023) ? 1023 : ref_c + 2;
    lo = (ref_c < 2) ? 0 : ref_c - 2;
    ph = model(hi); pl = model(lo);
    serve(s); last_hi = s; if (s != hi) nbad++;
    serve(s); last_lo = s; if (s != lo) nbad++;
    serve(s); last_c  = s; if (s != ref_c) nbad++;
    if (ph - pl > 8) ref_c = (ref_c == 1023) ? 1023 : ref_c + 1;
    else if (pl - ph > 8) ref_c = (ref_c == 0) ? 0 : ref_c - 1;
  endtask

  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({sample_req, busy, locked, err} !== 4'b0 || heater_code !== 10'd0 || peak_code !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%0d/%0d want=0000/0/0",
               {sample_req, busy, locked, err}, heater_code, peak_code);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_lock();
    int nb = 0;
    m_peak = 512; m_amp = 3000; force_zero = 1'b0;
    enable = 1'b1;
    run_sweep(nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL sweep_codes got=%0d wrong want=0", nb); end
    total++; if (busy !== 1'b1 || locked !== 1'b0) begin
      bad++; $display("FAIL goto_pk_flags got=%b%b want=10", busy, locked); end
    total++; if (int'(peak_code) !== ref_sweep_peak()) begin
      bad++; $display("FAIL peak_code got=%0d want=%0d", peak_code, ref_sweep_peak()); end
    ref_c = ref_sweep_peak();
    nb = 0;
    repeat (3) do_round(nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL lock_codes got=%0d wrong want=0", nb); end
    total++; if (locked !== 1'b1 || heater_code !== 10'd512) begin
      bad++; $display("FAIL locked_at_peak got=%b/%0d want=1/512", locked, heater_code); end
  endtask

  task automatic test_track_shift();
    int nb = 0;
    m_peak = 522;
    repeat (12) do_round(nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL track_codes got=%0d wrong want=0", nb); end
    total++; if (last_c < 521 || last_c > 523 || locked !== 1'b1) begin
      bad++; $display("FAIL track_settle got=%0d/%b want=522+-1/1", last_c, locked); end
  endtask

  task automatic test_loss();
    int nb = 0, s;
    force_zero = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      do_round(nb);
      total++;
      if (r < 4 && locked !== 1'b1) begin
        bad++; $display("FAIL loss_early round=%0d got=%b want=1", r, locked); end
      if (r == 4 && (locked !== 1'b0 || busy !== 1'b1)) begin
        bad++; $display("FAIL loss_drop got=%b%b want=01", locked, busy); end
    end
    force_zero = 1'b0;
    serve(s);
    total++; if (s !== 0 || nb !== 0) begin
      bad++; $display("FAIL loss_resweep got=%0d/%0d want=0/0", s, nb); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fail();
    int nb = 0, s;
    m_peak = 512; m_amp = 40;
    enable = 1'b1;
    run_sweep(nb);
    repeat (3) @(negedge clk);
    total++; if (nb !== 0 || err !== 1'b1 || heater_code !== 10'd0 || busy !== 1'b0 || locked !== 1'b0) begin
      bad++; $display("FAIL fail_state got=%0d/%b/%0d/%b/%b want=0/1/0/0/0", nb, err, heater_code, busy, locked); end
    enable = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL fail_exit got=%b%b want=00", err, busy); end
    m_amp = 3000;
    enable = 1'b1;
    serve(s);
    total++; if (s !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL fail_restart got=%0d/%b want=0/1", s, busy); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int nb = 0;
    m_peak = 0; m_amp = 3000;
    enable = 1'b1;
    run_sweep(nb);
    total++; if (nb !== 0 || peak_code !== 10'd0) begin
      bad++; $display("FAIL sat_low_sweep got=%0d/%0d want=0/0", nb, peak_code); end
    ref_c = 0;
    repeat (3) do_round(nb);
    total++; if (nb !== 0 || last_lo !== 0 || last_c !== 0 || locked !== 1'b1) begin
      bad++; $display("FAIL sat_low_track got=%0d/%0d/%0d/%b want=0/0/0/1", nb, last_lo, last_c, locked); end
    m_peak = 1023;
    restart();
    run_sweep(nb);
    total++; if (nb !== 0 || peak_code !== 10'd1020) begin
      bad++; $display("FAIL sat_high_sweep got=%0d/%0d want=0/1020", nb, peak_code); end
    ref_c = 1020;
    repeat (6) do_round(nb);
    total++; if (nb !== 0 || last_hi !== 1023 || last_c !== 1023 || locked !== 1'b1) begin
      bad++; $display("FAIL sat_high_track got=%0d/%0d/%0d/%b want=0/1023/1023/1", nb, last_hi, last_c, locked); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int s, nb = 0, n = 0;
    bit stray = 1'b0;
    m_peak = 20; m_amp = 3000;
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin serve(s); if (s != k * 4) nb++; end
    while (sample_req !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    total++; if (nb !== 0 || sample_req !== 1'b1) begin
      bad++; $display("FAIL abort_setup got=%0d/%b want=0/1", nb, sample_req); end
    enable = 1'b0;
    @(negedge clk);
    total++; if ({sample_req, busy, locked, err} !== 4'b0 || heater_code !== 10'd0 || peak_code !== 10'd20) begin
      bad++; $display("FAIL abort_idle got=%b/%0d/%0d want=0000/0/20",
                      {sample_req, busy, locked, err}, heater_code, peak_code); end
    pd_valid = 1'b1; @(negedge clk); pd_valid = 1'b0;
    repeat (5) begin if (sample_req !== 1'b0 || busy !== 1'b0) stray = 1'b1; @(negedge clk); end
    total++; if (stray) begin bad++; $display("FAIL stray_valid got=1 want=0"); end
    enable = 1'b1;
    repeat (3) serve(s);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({sample_req, busy, locked, err} !== 4'b0 || heater_code !== 10'd0 || peak_code !== 10'd0) begin
      bad++; $display("FAIL midrun_reset got=%b/%0d/%0d want=0000/0/0",
                      {sample_req, busy, locked, err}, heater_code, peak_code); end
    rst = 1'b0; enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep_lock();
    test_track_shift();
    test_loss();
    test_fail();
    test_saturate();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
